// File: rtl/control_pkg.sv
// Shared decode definitions for the main decoder: opcodes, immediate
// formats, vector-sequencer states and the bundled datapath controls.
package control_pkg;

    // Instruction opcodes; the V bit selects between the two variants.
    localparam logic [2:0] OP_R        = 3'b000;
    localparam logic [2:0] OP_STR      = 3'b001;
    localparam logic [2:0] OP_LDR      = 3'b010;
    localparam logic [2:0] OP_ILLEGAL  = 3'b011;
    localparam logic [2:0] OP_ADDI_BNQ = 3'b100;
    localparam logic [2:0] OP_SUBI_BGT = 3'b101;
    localparam logic [2:0] OP_MULI_BLT = 3'b110;
    localparam logic [2:0] OP_B_BEQ    = 3'b111;

    // Immediate formats selected by ImmSrc.
    localparam logic [1:0] IMM_I    = 2'b00;
    localparam logic [1:0] IMM_BL   = 2'b01;
    localparam logic [1:0] IMM_LANE = 2'b10;

    // Vector memory sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BEAT = 2'b01,
        DONE = 2'b10
    } vdec_state_t;

    // The seven datapath controls driven by the decoder.
    typedef struct packed {
        logic       branch;
        logic       mem_to_reg;
        logic       mem_w;
        logic       alu_src;
        logic       reg_w;
        logic       alu_op;
        logic [1:0] imm_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Single-cycle decode of every non-vector-memory instruction.
    // Vector load/store and the undefined opcode return all-zero controls.
    function automatic ctrl_t scalar_decode(input logic [2:0] opcode, input logic v);
        ctrl_t c;
        c = CTRL_NONE;
        case (opcode)
            OP_R: begin
                c.reg_w  = 1'b1;
                c.alu_op = 1'b1;
            end
            OP_ADDI_BNQ, OP_SUBI_BGT, OP_MULI_BLT: begin
                c.alu_src = 1'b1;
                if (v) begin
                    c.reg_w  = 1'b1;
                    c.alu_op = 1'b1;
                end else begin
                    c.branch  = 1'b1;
                    c.imm_src = IMM_I;
                end
            end
            OP_B_BEQ: begin
                c.branch  = 1'b1;
                c.alu_src = 1'b1;
                c.imm_src = v ? IMM_BL : IMM_I;
            end
            OP_STR: begin
                if (!v) begin
                    c.mem_w   = 1'b1;
                    c.alu_src = 1'b1;
                end
            end
            OP_LDR: begin
                if (!v) begin
                    c.mem_to_reg = 1'b1;
                    c.alu_src    = 1'b1;
                    c.reg_w      = 1'b1;
                end
            end
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lane_counter.sv
// Lane index counter for vector memory beats. clr wins over en so the
// sequencer can park the index at 0 on completion or flush.
module lane_counter #(
    parameter int LANES  = 4,
    parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    output logic [LANE_W-1:0] count,
    output logic              last
);

    logic [LANE_W-1:0] cnt_q;

    // Lane index register: clear has priority, then advance on enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count = cnt_q;
    assign last  = (cnt_q == LANE_W'(LANES - 1));

endmodule

// File: rtl/vector_main_decoder.sv
// Main decoder: scalar instructions decode combinationally while idle;
// vector ldr/str hand off to a beat sequencer that emits one memory beat
// per lane and stalls fetch/decode until the final beat is accepted.
//
// Memory handshake: the beat presented in BEAT is accepted in any cycle
// where mem_ready=1; otherwise the same lane and write enables are held.
// flush_i in BEAT abandons the sequence and wins over mem_ready.
module vector_main_decoder
    import control_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [2:0]        Opcode,
    input  logic              V,
    input  logic [2:0]        Funct,
    input  logic              mem_ready,
    output logic              Branch,
    output logic              MemtoReg,
    output logic              MemW,
    output logic              ALUSrc,
    output logic              RegW,
    output logic              ALUOp,
    output logic [1:0]        ImmSrc,
    output logic              VecOp,
    output logic [LANE_W-1:0] LaneIdx,
    output logic              stall_o,
    output logic              done_o,
    output logic              illegal_o,
    output vdec_state_t       state_o
);

    vdec_state_t       state_q;
    logic              load_q;
    logic              is_vec_mem;
    logic              start;
    logic              in_beat;
    logic              lane_en;
    logic              lane_clr;
    logic              lane_last;
    logic [LANE_W-1:0] lane_cnt;
    ctrl_t             ctrl;
    logic              vec_op;
    logic              stall;
    logic              done;
    logic              illegal;

    // Funct belongs to the ALU decoder; it has no effect on main decode.
    logic unused_funct;
    assign unused_funct = ^Funct;

    assign is_vec_mem = V && ((Opcode == OP_STR) || (Opcode == OP_LDR));
    assign start      = (state_q == IDLE) && valid_i && !flush_i && is_vec_mem;
    assign in_beat    = (state_q == BEAT);
    assign lane_en    = in_beat && mem_ready;
    assign lane_clr   = in_beat && (flush_i || (mem_ready && lane_last));

    lane_counter #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lane_en),
        .clr   (lane_clr),
        .count (lane_cnt),
        .last  (lane_last)
    );

    // Beat sequencer: latch load/store on detect, walk the lanes, pulse DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= BEAT;
                        load_q  <= (Opcode == OP_LDR);
                    end
                end
                BEAT: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (mem_ready && lane_last) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        ctrl    = CTRL_NONE;
        vec_op  = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (valid_i && !flush_i) begin
                        if (is_vec_mem) begin
                            stall = 1'b1;
                        end else begin
                            ctrl    = scalar_decode(Opcode, V);
                            illegal = (Opcode == OP_ILLEGAL);
                        end
                    end
                end
                BEAT: begin
                    vec_op       = 1'b1;
                    stall        = 1'b1;
                    ctrl.alu_src = 1'b1;
                    ctrl.imm_src = IMM_LANE;
                    if (load_q) begin
                        ctrl.mem_to_reg = 1'b1;
                        ctrl.reg_w      = 1'b1;
                    end else begin
                        ctrl.mem_w = 1'b1;
                    end
                end
                DONE: begin
                    done = 1'b1;
                end
                default: begin
                    ctrl = CTRL_NONE;
                end
            endcase
        end
    end

    assign Branch    = ctrl.branch;
    assign MemtoReg  = ctrl.mem_to_reg;
    assign MemW      = ctrl.mem_w;
    assign ALUSrc    = ctrl.alu_src;
    assign RegW      = ctrl.reg_w;
    assign ALUOp     = ctrl.alu_op;
    assign ImmSrc    = ctrl.imm_src;
    assign VecOp     = vec_op;
    assign LaneIdx   = lane_cnt;
    assign stall_o   = stall;
    assign done_o    = done;
    assign illegal_o = illegal;
    assign state_o   = state_q;

endmodule

// File: tb/tb_vector_main_decoder.sv
// Bench for vector_main_decoder: a LANES=4 and a LANES=1 instance share
// stimulus; a behavioural model predicts both every cycle, and directed
// scenarios pin the model with hand-computed expectations.
module tb_vector_main_decoder;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic       flush;
    logic [2:0] opcode;
    logic       v;
    logic [2:0] funct;
    logic       mem_ready;

    // LANES=4 instance outputs
    logic a_branch, a_m2r, a_memw, a_alusrc, a_regw, a_aluop;
    logic [1:0] a_imm;
    logic a_vec, a_stall, a_done, a_ill;
    logic [1:0] a_lane;
    control_pkg::vdec_state_t a_state;

    // LANES=1 instance outputs
    logic b_branch, b_m2r, b_memw, b_alusrc, b_regw, b_aluop;
    logic [1:0] b_imm;
    logic b_vec, b_stall, b_done, b_ill;
    logic [0:0] b_lane;
    control_pkg::vdec_state_t b_state;

    logic [11:0] a_out;
    logic [11:0] b_out;
    assign a_out = {a_branch, a_m2r, a_memw, a_alusrc, a_regw, a_aluop, a_imm, a_vec, a_stall, a_done, a_ill};
    assign b_out = {b_branch, b_m2r, b_memw, b_alusrc, b_regw, b_aluop, b_imm, b_vec, b_stall, b_done, b_ill};

    int n_checks = 0;
    int n_err    = 0;

    vector_main_decoder #(.LANES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .flush_i(flush),
        .Opcode(opcode), .V(v), .Funct(funct), .mem_ready(mem_ready),
        .Branch(a_branch), .MemtoReg(a_m2r), .MemW(a_memw), .ALUSrc(a_alusrc),
        .RegW(a_regw), .ALUOp(a_aluop), .ImmSrc(a_imm), .VecOp(a_vec),
        .LaneIdx(a_lane), .stall_o(a_stall), .done_o(a_done),
        .illegal_o(a_ill), .state_o(a_state)
    );

    vector_main_decoder #(.LANES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .flush_i(flush),
        .Opcode(opcode), .V(v), .Funct(funct), .mem_ready(mem_ready),
        .Branch(b_branch), .MemtoReg(b_m2r), .MemW(b_memw), .ALUSrc(b_alusrc),
        .RegW(b_regw), .ALUOp(b_aluop), .ImmSrc(b_imm), .VecOp(b_vec),
        .LaneIdx(b_lane), .stall_o(b_stall), .done_o(b_done),
        .illegal_o(b_ill), .state_o(b_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Index 0 models the LANES=4 build, index 1 the LANES=1 build.
    int lanes_of [2] = '{4, 1};
    bit m_busy [2];
    bit m_load [2];
    bit m_done [2];
    int m_lane [2];

    // Packing: {br, m2r, mw, alusrc, regw, aluop, imm[1:0], vec, stall, done, illegal}
    function automatic logic [11:0] scalar_exp(input logic [2:0] op, input logic vb);
        bit br = 0, m2r = 0, mw = 0, as = 0, rw = 0, ao = 0, st = 0, il = 0;
        logic [1:0] imm = 2'b00;
        case (op)
            3'd0: begin rw = 1; ao = 1; end
            3'd4, 3'd5, 3'd6: begin
                as = 1;
                if (vb) begin rw = 1; ao = 1; end
                else br = 1;
            end
            3'd7: begin br = 1; as = 1; imm = vb ? 2'b01 : 2'b00; end
            3'd1: if (vb) st = 1; else begin mw = 1; as = 1; end
            3'd2: if (vb) st = 1; else begin m2r = 1; as = 1; rw = 1; end
            default: il = 1;
        endcase
        return {br, m2r, mw, as, rw, ao, imm, 1'b0, st, 1'b0, il};
    endfunction

    function automatic logic [11:0] model_exp(input int i);
        logic [11:0] e;
        e = '0;
        if (!rst_n) return '0;
        if (m_done[i]) begin
            e[1] = 1'b1;
        end else if (m_busy[i]) begin
            e[3]   = 1'b1;
            e[2]   = 1'b1;
            e[8]   = 1'b1;
            e[5:4] = 2'b10;
            if (m_load[i]) begin e[10] = 1'b1; e[7] = 1'b1; end
            else e[9] = 1'b1;
        end else if (valid && !flush) begin
            e = scalar_exp(opcode, v);
        end
        return e;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_load[i] = 0; m_done[i] = 0; m_lane[i] = 0;
        end
    endtask

    task automatic advance_model();
        for (int i = 0; i < 2; i++) begin
            if (m_done[i]) begin
                m_done[i] = 0;
            end else if (m_busy[i]) begin
                if (flush) begin
                    m_busy[i] = 0; m_lane[i] = 0;
                end else if (mem_ready) begin
                    if (m_lane[i] == lanes_of[i] - 1) begin
                        m_busy[i] = 0; m_lane[i] = 0; m_done[i] = 1;
                    end else begin
                        m_lane[i]++;
                    end
                end
            end else if (valid && !flush && v && (opcode == 3'd1 || opcode == 3'd2)) begin
                m_busy[i] = 1; m_lane[i] = 0; m_load[i] = (opcode == 3'd2);
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    // Every cycle: compare both instances at the falling edge, then step the
    // model at the rising edge using the inputs the DUT also sampled.
    initial begin
        reset_model();
        forever begin
            @(negedge clk);
            if (!rst_n) reset_model();
            n_checks++;
            if (a_out !== model_exp(0) || 32'(a_lane) !== m_lane[0]) begin
                n_err++;
                $display("FAIL cycle_lanes4 t=%0t got=%h/lane%0d exp=%h/lane%0d",
                         $time, a_out, a_lane, model_exp(0), m_lane[0]);
            end
            n_checks++;
            if (b_out !== model_exp(1) || 32'(b_lane) !== m_lane[1]) begin
                n_err++;
                $display("FAIL cycle_lanes1 t=%0t got=%h/lane%0d exp=%h/lane%0d",
                         $time, b_out, b_lane, model_exp(1), m_lane[1]);
            end
            @(posedge clk);
            if (!rst_n) reset_model();
            else advance_model();
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit vl, input bit fl, input logic [2:0] op,
                        input bit vv, input bit mr);
        @(posedge clk);
        #1;
        valid     = vl;
        flush     = fl;
        opcode    = op;
        v         = vv;
        mem_ready = mr;
        funct     = 3'($urandom_range(0, 7));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 3'd0, 0, 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int  stalls, beats, cyc, dones;
        bit  seen_done;

        rst_n = 0; valid = 1; flush = 0; opcode = 3'd0; v = 0; funct = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset: valid add on the inputs must still produce all-zero outputs.
        chk("reset_regw", a_regw, 0);
        chk("reset_aluop", a_aluop, 0);
        chk("reset_stall", a_stall, 0);
        chk("reset_lane", a_lane, 0);
        chk("reset_state_a", a_state, control_pkg::IDLE);
        chk("reset_state_b", b_state, control_pkg::IDLE);
        @(posedge clk);
        #2 rst_n = 1;

        // Scalar sweep of every opcode/V pair that does not start a vector op.
        for (int op = 0; op < 8; op++) begin
            for (int vb = 0; vb < 2; vb++) begin
                if (!(vb == 1 && (op == 1 || op == 2))) begin
                    step(1, 0, 3'(op), 1'(vb), 1);
                    if (op == 4 && vb == 1) begin
                        chk("addi_alusrc", a_alusrc, 1);
                        chk("addi_regw", a_regw, 1);
                        chk("addi_aluop", a_aluop, 1);
                        chk("addi_branch", a_branch, 0);
                    end
                    if (op == 7 && vb == 1) begin
                        chk("b_immsrc", a_imm, 2'b01);
                        chk("b_branch", a_branch, 1);
                    end
                    if (op == 3) begin
                        chk("illegal", a_ill, 1);
                        chk("illegal_regw", a_regw, 0);
                    end
                end
            end
        end
        step(0, 0, 3'd0, 0, 1);
        chk("novalid_out", a_out, 0);
        step(1, 1, 3'd0, 0, 1);
        chk("flush_idle_out", a_out, 0);

        // vstr, mem_ready tied high: stall 5 cycles, MemW on lanes 0..3, one done.
        step(1, 0, 3'd1, 1, 1);
        chk("vstr_detect_stall", a_stall, 1);
        chk("vstr_detect_memw", a_memw, 0);
        stalls = 1; beats = 0; seen_done = 0;
        for (int k = 0; k < 12 && !seen_done; k++) begin
            step(0, 0, 3'd0, 0, 1);
            if (a_done) begin
                seen_done = 1;
                chk("vstr_done_stall", a_stall, 0);
            end else begin
                if (a_stall) stalls++;
                chk("vstr_memw", a_memw, 1);
                chk("vstr_lane", a_lane, beats);
                beats++;
            end
        end
        chk("vstr_done_seen", seen_done, 1);
        chk("vstr_stall_cycles", stalls, 5);
        step(0, 0, 3'd0, 0, 1);
        chk("vstr_done_once", a_done, 0);
        idle(2);

        // vldr, mem_ready low on beats 1 and 2: lane holds at 1, latency 8.
        step(1, 0, 3'd2, 1, 1);
        cyc = 1; seen_done = 0;
        for (int b = 0; b < 15 && !seen_done; b++) begin
            step(0, 0, 3'd0, 0, !(b == 1 || b == 2));
            cyc++;
            if (a_done) begin
                seen_done = 1;
            end else begin
                chk("vldr_regw", a_regw, 1);
                if (b >= 1 && b <= 3) chk("vldr_lane_hold", a_lane, 1);
            end
        end
        chk("vldr_latency", cyc, 8);
        idle(2);

        // Flush at lane 2 together with mem_ready: back to IDLE, no done.
        dones = 0;
        step(1, 0, 3'd1, 1, 1);
        step(0, 0, 3'd0, 0, 1);
        step(0, 0, 3'd0, 0, 1);
        step(0, 1, 3'd0, 0, 1);
        chk("flush_at_lane2", a_lane, 2);
        if (a_done) dones++;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 3'd0, 0, 1);
            if (k == 0) begin
                chk("flush_lane0", a_lane, 0);
                chk("flush_stall", a_stall, 0);
                chk("flush_vecop", a_vec, 0);
            end
            if (a_done) dones++;
        end
        chk("flush_no_done", dones, 0);

        // Asynchronous reset in the middle of a vldr.
        step(1, 0, 3'd2, 1, 1);
        step(0, 0, 3'd0, 0, 1);
        step(0, 0, 3'd0, 0, 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_stall", a_stall, 0);
        chk("arst_vecop", a_vec, 0);
        chk("arst_regw", a_regw, 0);
        chk("arst_lane", a_lane, 0);
        @(posedge clk);
        #3 rst_n = 1;
        step(1, 0, 3'd0, 0, 0);
        chk("post_rst_regw", a_regw, 1);
        chk("post_rst_aluop", a_aluop, 1);
        chk("post_rst_stall", a_stall, 0);
        idle(2);

        // LANES=1 instance: vldr takes exactly 3 cycles with LaneIdx 0.
        step(1, 0, 3'd2, 1, 1);
        chk("l1_detect_stall", b_stall, 1);
        cyc = 1; seen_done = 0;
        for (int k = 0; k < 8 && !seen_done; k++) begin
            step(0, 0, 3'd0, 0, 1);
            cyc++;
            if (b_done) begin
                seen_done = 1;
            end else begin
                chk("l1_lane", b_lane, 0);
                chk("l1_regw", b_regw, 1);
            end
        end
        chk("l1_latency", cyc, 3);
        idle(6);

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                @(posedge clk);
                #2 rst_n = 0;
                @(posedge clk);
                #2 rst_n = 1;
            end else begin
                step($urandom_range(0, 9) < 8,
                     $urandom_range(0, 19) == 0,
                     3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) < 7);
            end
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
